// File: rtl/crypto_block_sequencer.sv
// ============================================================================
// crypto_block_sequencer
// ----------------------------------------------------------------------------
// Purpose
//   Steps a block-cipher engine through one job at a time. A job descriptor
//   holds the algorithm, the key and a block count. For every block the
//   sequencer does four things in order:
//     1. takes one plaintext block from the input stream,
//     2. pulses eng_start,
//     3. waits for eng_done,
//     4. offers the engine result on the output stream until it is accepted.
//   When the last block has been accepted, job_done pulses for one cycle.
//
// Ports
//   clk, rst        single clock; synchronous active-high reset
//   job_*           job descriptor handshake (algo 0:AES 1:SM4, 128b key,
//                   LEN_W-bit block count)
//   s_*             plaintext block input stream (valid/ready, 128b)
//   m_*             ciphertext block output stream (valid/ready, 128b)
//   eng_*           engine control and data (algo select, key, start pulse,
//                   input block, done strobe, output block)
//   job_done        one-cycle pulse at job end
//   err_timeout     sticky engine-timeout flag
//
// Configuration
//   CRYPTO_SEQ_TIMEOUT_EN  When defined, a counter in WAIT aborts the job if
//                          the engine stays silent for TIMEOUT_CYC cycles.
//                          The abort sets err_timeout and goes to DONE.
//                          When undefined, WAIT waits indefinitely and
//                          err_timeout is tied to 0.
// ============================================================================
module crypto_block_sequencer #(
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,

    // Job descriptor
    input  logic             job_valid,
    output logic             job_ready,
    input  logic             job_algo,
    input  logic [127:0]     job_key,
    input  logic [LEN_W-1:0] job_nblk,

    // Plaintext input stream
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [127:0]     s_data,

    // Ciphertext output stream
    output logic             m_valid,
    input  logic             m_ready,
    output logic [127:0]     m_data,

    // Crypto engine
    output logic             eng_algo_sel,
    output logic [127:0]     eng_key,
    output logic             eng_start,
    output logic [127:0]     eng_din,
    input  logic             eng_done,
    input  logic [127:0]     eng_dout,

    // Status
    output logic             job_done,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             algo_q, algo_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     din_q, din_d;
    logic [127:0]     dout_q, dout_d;
    logic [LEN_W-1:0] rem_q, rem_d;

`ifdef CRYPTO_SEQ_TIMEOUT_EN
    // The counter only has to hold 0 .. TIMEOUT_CYC-1.
    localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
`else
    // Without the timeout build, TIMEOUT_CYC has no function.
    // This reference keeps the parameter from being reported as dangling.
    logic [31:0] timeout_cyc_unused;
    assign timeout_cyc_unused = 32'(TIMEOUT_CYC);
`endif

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples pre-edge values no matter how statements are ordered.
            state_q <= ST_IDLE;
            algo_q  <= 1'b0;
            key_q   <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            algo_q  <= algo_d;
            key_q   <= key_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here first takes its hold value.
        // No branch of the case can then leave one unassigned and infer a latch.
        state_d = state_q;
        algo_d  = algo_q;
        key_d   = key_q;
        din_d   = din_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    // Algorithm and key are frozen here.
                    // They stay frozen until the next accept.
                    algo_d = job_algo;
                    key_d  = job_key;
                    rem_d  = job_nblk;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
                    err_d  = 1'b0;
`endif
                    state_d = (job_nblk == '0) ? ST_DONE : ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (s_valid) begin
                    din_d   = s_data;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                // eng_done during START is ignored on purpose.
                // It cannot belong to the block just being started.
                state_d = ST_WAIT;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end

            ST_WAIT: begin
                if (eng_done) begin
                    dout_d  = eng_dout;
                    state_d = ST_OUT;
                end
`ifdef CRYPTO_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    // The engine missed its deadline.
                    // The job is abandoned; the remaining blocks are not taken.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            ST_OUT: begin
                if (m_ready) begin
                    // The exit test is on 1, not 0.
                    // A count of 2^LEN_W-1 therefore never wraps.
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = rem_q - 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: pure decodes of registered state.
    // There is no combinational path from any input to any output.
    // ------------------------------------------------------------------------
    assign job_ready    = (state_q == ST_IDLE);
    assign s_ready      = (state_q == ST_LOAD);
    assign eng_start    = (state_q == ST_START);
    assign m_valid      = (state_q == ST_OUT);
    assign job_done     = (state_q == ST_DONE);

    assign eng_algo_sel = algo_q;
    assign eng_key      = key_q;
    assign eng_din      = din_q;
    assign m_data       = dout_q;

`ifdef CRYPTO_SEQ_TIMEOUT_EN
    assign err_timeout  = err_q;
`else
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_crypto_block_sequencer.sv
// ============================================================================
// tb_crypto_block_sequencer
// ----------------------------------------------------------------------------
// Directed bench with a scoreboard.
//   Stimulus: each issued job pushes the expected ciphertext of every block
//   into exp_q.
//   Monitor: pops exp_q and compares on every output handshake.
//   Engine model: result = block ^ key ^ {128{algo}}, returned a programmable
//   number of cycles after eng_start.
//   LEN_W is reduced to 4, so the full-count job (15 blocks) stays short.
// ============================================================================
module tb_crypto_block_sequencer;

    localparam int LEN_W       = 4;
    localparam int TIMEOUT_CYC = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             job_valid, job_ready, job_algo;
    logic [127:0]     job_key;
    logic [LEN_W-1:0] job_nblk;
    logic             s_valid, s_ready;
    logic [127:0]     s_data;
    logic             m_valid, m_ready;
    logic [127:0]     m_data;
    logic             eng_algo_sel, eng_start, eng_done;
    logic [127:0]     eng_key, eng_din, eng_dout;
    logic             job_done, err_timeout;

    always #5 clk = ~clk;

    crypto_block_sequencer #(
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_algo     (job_algo),
        .job_key      (job_key),
        .job_nblk     (job_nblk),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .eng_algo_sel (eng_algo_sel),
        .eng_key      (eng_key),
        .eng_start    (eng_start),
        .eng_din      (eng_din),
        .eng_done     (eng_done),
        .eng_dout     (eng_dout),
        .job_done     (job_done),
        .err_timeout  (err_timeout)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] src_q[$];
    logic [127:0] exp_q[$];

    // Event counters and cycle stamps, written only by the monitor.
    int cyc       = 0;
    int s_cnt     = 0;
    int m_cnt     = 0;
    int start_cnt = 0;
    int jd_cnt    = 0;
    int mv_cnt    = 0;
    int s_rdy_cnt = 0;
    int s_cyc     = -10;
    int m_cyc     = 0;
    int start_cyc = 0;
    int jd_cyc    = 0;
    int acc_cyc   = 0;
    int done_cyc  = -10;

    logic         mv_prev   = 1'b0;
    logic         jr_prev   = 1'b1;
    logic         algo_prev = 1'b0;
    logic [127:0] key_prev  = '0;

    // Snapshots taken by the stimulus before each job.
    int s0, m0, st0, jd0, mv0, sr0;

    // Engine model state
    int           eng_delay  = 11;
    bit           eng_enable = 1'b1;
    int           spur_req   = 0;
    int           spur_ack   = 0;
    bit           eng_busy   = 1'b0;
    int           eng_cd     = 0;
    logic [127:0] cap_din, cap_key;
    logic         cap_algo;
    bit           src_hs;

    function automatic logic [127:0] eng_xform(input logic [127:0] blk,
                                               input logic [127:0] k,
                                               input logic         a);
        return blk ^ k ^ {128{a}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: samples on the falling edge
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (job_valid && job_ready) acc_cyc = cyc;
            if (s_ready) s_rdy_cnt++;
            if (s_valid && s_ready) begin
                s_cnt++;
                s_cyc = cyc;
            end
            if (eng_start) begin
                start_cnt++;
                start_cyc = cyc;
                check("start_after_s_hs", 128'(cyc), 128'(s_cyc + 1));
            end
            if (m_valid && !mv_prev)
                check("m_valid_after_done", 128'(cyc), 128'(done_cyc + 1));
            if (eng_done) done_cyc = cyc;
            if (m_valid) mv_cnt++;
            if (m_valid && m_ready) begin
                m_cnt++;
                m_cyc = cyc;
                if (exp_q.size() == 0) fail_now("m_unexpected_output");
                else check("m_data", m_data, exp_q.pop_front());
            end
            if (job_done) begin
                jd_cnt++;
                jd_cyc = cyc;
            end
            // Algorithm and key must not move while a job is in flight.
            if (!job_ready && !jr_prev) begin
                check("eng_key_stable", eng_key, key_prev);
                check("eng_algo_stable", 128'(eng_algo_sel), 128'(algo_prev));
            end
            key_prev  = eng_key;
            algo_prev = eng_algo_sel;
            mv_prev   = m_valid;
            jr_prev   = job_ready;
        end
    end

    // ------------------------------------------------------------------------
    // Source: presents the head of src_q and pops it after a handshake
    // ------------------------------------------------------------------------
    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge clk);
            src_hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (src_hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Engine model
    // ------------------------------------------------------------------------
    initial begin
        eng_done = 1'b0;
        eng_dout = '0;
        forever begin
            @(negedge clk);
            if (eng_start && eng_enable) begin
                eng_busy = 1'b1;
                eng_cd   = eng_delay;
                cap_din  = eng_din;
                cap_key  = eng_key;
                cap_algo = eng_algo_sel;
            end
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (spur_req != spur_ack) begin
                spur_ack++;
                eng_done = 1'b1;
                eng_dout = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
            end else if (eng_busy) begin
                eng_cd--;
                if (eng_cd <= 0) begin
                    eng_busy = 1'b0;
                    eng_done = 1'b1;
                    eng_dout = eng_xform(cap_din, cap_key, cap_algo);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic snap();
        s0  = s_cnt;
        m0  = m_cnt;
        st0 = start_cnt;
        jd0 = jd_cnt;
        mv0 = mv_cnt;
        sr0 = s_rdy_cnt;
    endtask

    task automatic check_counts(input string tag, input int ns, input int nm,
                                input int nst, input int njd);
        check({tag, "_s_handshakes"}, 128'(s_cnt - s0), 128'(ns));
        check({tag, "_m_handshakes"}, 128'(m_cnt - m0), 128'(nm));
        check({tag, "_eng_starts"}, 128'(start_cnt - st0), 128'(nst));
        check({tag, "_job_done_pulses"}, 128'(jd_cnt - jd0), 128'(njd));
    endtask

    task automatic issue_job(input logic a, input logic [127:0] k, input int n,
                             input logic [127:0] base, input bit push_src);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (push_src) src_q.push_back(base + 128'(i));
            exp_q.push_back(eng_xform(base + 128'(i), k, a));
        end
        @(posedge clk);
        #1;
        job_valid = 1'b1;
        job_algo  = a;
        job_key   = k;
        job_nblk  = LEN_W'(n);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (job_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("job_accept");
        @(posedge clk);
        #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_job_done(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(posedge clk);
            if (jd_cnt != jd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now({tag, "_job_done"});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(posedge clk);
            #1;
            if (start_cnt != st0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("eng_start_seen");
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    localparam logic [127:0] K_A = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] K_B = 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C;
    localparam logic [127:0] K_1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] K_2 = 128'hA5A5_A5A5_5A5A_5A5A_F0F0_F0F0_0F0F_0F0F;

    initial begin
        rst       = 1'b1;
        job_valid = 1'b0;
        job_algo  = 1'b0;
        job_key   = '0;
        job_nblk  = '0;
        m_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_job_ready", 128'(job_ready), 128'd1);
        check("rst_s_ready", 128'(s_ready), 128'd0);
        check("rst_m_valid", 128'(m_valid), 128'd0);
        check("rst_eng_start", 128'(eng_start), 128'd0);
        check("rst_job_done", 128'(job_done), 128'd0);
        check("rst_err_timeout", 128'(err_timeout), 128'd0);
        check("rst_eng_din", eng_din, 128'd0);
        check("rst_m_data", m_data, 128'd0);
        check("rst_eng_key", eng_key, 128'd0);
        check("rst_eng_algo_sel", 128'(eng_algo_sel), 128'd0);

        // Three blocks, free-flowing source and sink, engine latency 11
        m_ready   = 1'b1;
        eng_delay = 11;
        snap();
        issue_job(1'b0, K_A, 3, 128'h1000_0000_0000_0000_0000_0000_0000_0001, 1'b1);
        wait_job_done("j3", 200);
        check_counts("j3", 3, 3, 3, 1);
        check("j3_done_after_last_m", 128'(jd_cyc), 128'(m_cyc + 1));

        // Two blocks; output held off after the first block appears
        m_ready   = 1'b0;
        eng_delay = 3;
        snap();
        issue_job(1'b0, K_B, 2, 128'h3243_F6A8_885A_308D_3131_98A2_E037_0734, 1'b1);
        begin : hold_blk
            bit ok;
            int st_hold;
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(posedge clk);
                #1;
                if (m_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) fail_now("hold_m_valid");
            st_hold = start_cnt;
            for (int t = 0; t < 5; t++) begin
                @(posedge clk);
                #1;
                check("hold_m_valid", 128'(m_valid), 128'd1);
                check("hold_m_data", m_data,
                      eng_xform(128'h3243_F6A8_885A_308D_3131_98A2_E037_0734, K_B, 1'b0));
                check("hold_s_ready", 128'(s_ready), 128'd0);
            end
            check("hold_no_eng_start", 128'(start_cnt - st_hold), 128'd0);
        end
        m_ready = 1'b1;
        wait_job_done("hold", 100);
        check_counts("hold", 2, 2, 2, 1);

        // Zero-block job
        snap();
        issue_job(1'b0, K_A, 0, 128'd0, 1'b1);
        wait_job_done("nblk0", 20);
        check_counts("nblk0", 0, 0, 0, 1);
        check("nblk0_done_latency", 128'(jd_cyc), 128'(acc_cyc + 1));
        check("nblk0_no_s_ready", 128'(s_rdy_cnt - sr0), 128'd0);

        // SM4/K1 with a spurious eng_done in LOAD, then AES/K2
        eng_delay = 4;
        snap();
        issue_job(1'b1, K_1, 1, 128'h6BC1_BEE2_2E40_9F96_E93D_7E11_7393_172A, 1'b0);
        begin : spur_blk
            bit ok;
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(posedge clk);
                #1;
                if (s_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) fail_now("spur_s_ready");
        end
        check("j_k1_algo", 128'(eng_algo_sel), 128'd1);
        check("j_k1_key", eng_key, K_1);
        spur_req++;
        repeat (3) @(posedge clk);
        #1;
        check("spur_no_m_valid", 128'(m_valid), 128'd0);
        check("spur_still_load", 128'(s_ready), 128'd1);
        check("spur_no_start", 128'(start_cnt - st0), 128'd0);
        src_q.push_back(128'h6BC1_BEE2_2E40_9F96_E93D_7E11_7393_172A);
        wait_job_done("k1", 100);
        check_counts("k1", 1, 1, 1, 1);

        snap();
        issue_job(1'b0, K_2, 1, 128'hAE2D_8A57_1E03_AC9C_9EB7_6FAC_45AF_8E51, 1'b1);
        check("j_k2_algo", 128'(eng_algo_sel), 128'd0);
        check("j_k2_key", eng_key, K_2);
        wait_job_done("k2", 100);
        check_counts("k2", 1, 1, 1, 1);

        // Full-count job: 2^LEN_W-1 blocks, shortest engine latency
        eng_delay = 1;
        snap();
        issue_job(1'b1, K_B, 15, 128'h5555_0000_0000_0000_0000_0000_0000_0000, 1'b1);
        wait_job_done("full", 400);
        check_counts("full", 15, 15, 15, 1);

        // Reset while waiting on the engine; its done arrives after reset
        eng_delay = 20;
        snap();
        issue_job(1'b0, K_A, 1, 128'h7777_0000_0000_0000_0000_0000_0000_0007, 1'b1);
        wait_start(30);
        repeat (3) @(posedge clk);
        pulse_reset();
        check("rstw_job_ready", 128'(job_ready), 128'd1);
        check("rstw_eng_key", eng_key, 128'd0);
        repeat (30) @(posedge clk);
        #1;
        check("rstw_no_m_valid", 128'(mv_cnt - mv0), 128'd0);
        check("rstw_no_job_done", 128'(jd_cnt - jd0), 128'd0);
        check("rstw_idle", 128'(job_ready), 128'd1);
        check("rstw_m_data", m_data, 128'd0);

        // Engine that never answers
        eng_enable = 1'b0;
        snap();
`ifdef CRYPTO_SEQ_TIMEOUT_EN
        issue_job(1'b0, K_A, 2, 128'h9999_0000_0000_0000_0000_0000_0000_0009, 1'b1);
        wait_job_done("tmo", 100);
        check("tmo_done_cycle", 128'(jd_cyc), 128'(start_cyc + 17));
        check("tmo_err_set", 128'(err_timeout), 128'd1);
        check_counts("tmo", 1, 0, 1, 1);
        src_q.delete();
        exp_q.delete();
        eng_enable = 1'b1;
        eng_delay  = 2;
        snap();
        issue_job(1'b1, K_2, 1, 128'hABCD_0000_0000_0000_0000_0000_0000_0001, 1'b1);
        check("tmo_err_cleared", 128'(err_timeout), 128'd0);
        wait_job_done("post_tmo", 100);
        check_counts("post_tmo", 1, 1, 1, 1);
`else
        issue_job(1'b0, K_A, 1, 128'h9999_0000_0000_0000_0000_0000_0000_0009, 1'b1);
        wait_start(30);
        repeat (40) @(posedge clk);
        #1;
        check("stall_err_low", 128'(err_timeout), 128'd0);
        check("stall_no_m_valid", 128'(mv_cnt - mv0), 128'd0);
        check("stall_no_job_done", 128'(jd_cnt - jd0), 128'd0);
        check("stall_not_idle", 128'(job_ready), 128'd0);
        pulse_reset();
        eng_enable = 1'b1;
        eng_delay  = 2;
        snap();
        issue_job(1'b1, K_2, 1, 128'hABCD_0000_0000_0000_0000_0000_0000_0001, 1'b1);
        wait_job_done("post_stall", 100);
        check_counts("post_stall", 1, 1, 1, 1);
`endif

        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time limit (cycle %0d)", cyc);
        $fatal(1, "global time limit reached");
    end

endmodule
